// File: rtl/moore_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : moore_seq_det
// Purpose  : Parametrised Moore sequence detector. Tracks how many leading
//            bits of a compile-time PATTERN (MSB-first) are currently matched
//            on a 1-bit serial input and flags a full match. The next-state
//            table is a KMP automaton built at elaboration by a constant
//            function, so no search logic exists at run time.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-high reset
//            en         - sample enable; data consumed only when en=1
//            data       - serial data bit
//            out        - match flag, high while state == PAT_LEN
//            state      - matched-prefix length, 0..PAT_LEN
//            match_cnt  - saturating match counter (CNT_W bits)
// Macro    : MOORE_SEQ_DET_CNT_EN - when defined the match counter is built;
//            otherwise match_cnt is tied to zero (port list unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module moore_seq_det #(
    parameter int          PAT_LEN = 4,
    parameter logic [15:0] PATTERN = 16'b1011,
    parameter bit          OVERLAP = 1'b1,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             data,
    output logic             out,
    output logic [4:0]       state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [4:0] c_pat_len = PAT_LEN[4:0];

    if ((PAT_LEN < 1) || (PAT_LEN > 16)) begin : g_bad_len
        $error("moore_seq_det: PAT_LEN must lie in 1..16");
    end

    // Pattern bit in reception order: index 0 is the first bit received.
    function automatic logic f_pat(input int i);
        logic [15:0] pv;
        pv = PATTERN >> (PAT_LEN - 1 - i);
        return pv[0];
    endfunction

    // Next matched-prefix length from prefix length s_in on input bit b.
    // w = first s pattern bits followed by b; the result is the longest
    // pattern prefix that is also a suffix of w. Without overlap, a full
    // match restarts as if from the empty state.
    function automatic logic [4:0] f_next(input int s_in, input logic b);
        int   s;
        int   len;
        int   best;
        int   idx;
        logic ok;
        logic wbit;
        s    = s_in;
        best = 0;
        if ((s == PAT_LEN) && !OVERLAP) begin
            s = 0;
        end
        if (s <= PAT_LEN) begin
            len = s + 1;
            for (int k = 1; k <= 17; k++) begin
                if ((k <= PAT_LEN) && (k <= len)) begin
                    ok = 1'b1;
                    for (int j = 0; j < 17; j++) begin
                        if (j < k) begin
                            idx  = len - k + j;
                            wbit = (idx < s) ? f_pat(idx) : b;
                            if (f_pat(j) != wbit) begin
                                ok = 1'b0;
                            end
                        end
                    end
                    if (ok) begin
                        best = k;
                    end
                end
            end
        end
        return best[4:0];
    endfunction

    // Table spans the full 5-bit state space; unreachable rows hold 0.
    logic [4:0] w_tbl [0:31][0:1];

    for (genvar gs = 0; gs < 32; gs++) begin : g_tbl_s
        for (genvar gb = 0; gb < 2; gb++) begin : g_tbl_b
            localparam logic [4:0] c_nxt = f_next(gs, (gb == 1));
            assign w_tbl[gs][gb] = c_nxt;
        end
    end

    logic [4:0] r_state;
    logic [4:0] w_nxt;

    // State register: the state is the matched-prefix length itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= 5'd0;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state and output logic. data is only looked at when en=1, so
    // an unknown data bit during a gap cannot reach the state register.
    always_comb begin
        w_nxt = r_state;
        if (en) begin
            w_nxt = w_tbl[r_state][data];
        end
    end

    assign state = r_state;
    assign out   = (r_state == c_pat_len);

`ifdef MOORE_SEQ_DET_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_cnt;

    // Counts edges that enter the match state; holds at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (en && (w_nxt == c_pat_len) && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_moore_seq_det
// Purpose  : Self-checking bench for moore_seq_det. Four instances cover the
//            1011 overlap / non-overlap detectors, a 1-bit saturating case
//            and a 110 fallback case. Stimulus pushes hand-computed expected
//            values into a queue; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moore_seq_det;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] en_v;
    logic [3:0] data_v;

    logic [4:0] st_a, st_b, st_c, st_d;
    logic       out_a, out_b, out_c, out_d;
    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [1:0] cnt_c;

    moore_seq_det #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en_v[0]), .data(data_v[0]),
        .out(out_a), .state(st_a), .match_cnt(cnt_a));

    moore_seq_det #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en_v[1]), .data(data_v[1]),
        .out(out_b), .state(st_b), .match_cnt(cnt_b));

    moore_seq_det #(.PAT_LEN(1), .PATTERN(16'b1), .OVERLAP(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .en(en_v[2]), .data(data_v[2]),
        .out(out_c), .state(st_c), .match_cnt(cnt_c));

    moore_seq_det #(.PAT_LEN(3), .PATTERN(16'b110), .OVERLAP(1'b1), .CNT_W(8)) u_d (
        .clk(clk), .reset(reset), .en(en_v[3]), .data(data_v[3]),
        .out(out_d), .state(st_d), .match_cnt(cnt_d));

    typedef struct {
        int         id;
        logic [4:0] st;
        logic       o;
        logic [7:0] cnt;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Stimulus tables (hand-computed expectations)
    int   t1_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int   t1_sa[7]   = '{1, 2, 3, 4, 2, 3, 4};
    int   t1_ca[7]   = '{0, 0, 0, 1, 1, 1, 2};
    int   t1_sb[7]   = '{1, 2, 3, 4, 0, 1, 1};
    int   t1_cb[7]   = '{0, 0, 0, 1, 1, 1, 1};

    logic t3_en[9]   = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    logic t3_d[9]    = '{1, 0, 1, 0, 1, 1'bx, 1, 0, 1};
    int   t3_sa[9]   = '{1, 2, 3, 3, 3, 3, 4, 4, 4};
    int   t3_ca[9]   = '{2, 2, 2, 2, 2, 2, 3, 3, 3};

    int   t4_bits[4] = '{1, 0, 1, 1};
    int   t4_sa[4]   = '{1, 2, 3, 4};
    int   t4_ca[4]   = '{0, 0, 0, 1};

    int   t6_bits[4] = '{1, 1, 1, 0};
    int   t6_sd[4]   = '{1, 2, 2, 3};
    int   t6_cd[4]   = '{0, 0, 0, 1};

    function automatic logic [7:0] ecnt(input int c);
`ifdef MOORE_SEQ_DET_CNT_EN
        return c[7:0];
`else
        return (c < 0) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic get_dut(input int id, output logic [4:0] st, output logic o,
                           output logic [7:0] c);
        case (id)
            0:       begin st = st_a; o = out_a; c = cnt_a; end
            1:       begin st = st_b; o = out_b; c = cnt_b; end
            2:       begin st = st_c; o = out_c; c = {6'd0, cnt_c}; end
            default: begin st = st_d; o = out_d; c = cnt_d; end
        endcase
    endtask

    task automatic compare(input string nm, input int id, input logic [4:0] est,
                           input logic eo, input logic [7:0] ec);
        logic [4:0] ast;
        logic       ao;
        logic [7:0] ac;
        get_dut(id, ast, ao, ac);
        checks++;
        if ((ast !== est) || (ao !== eo) || (ac !== ec)) begin
            failures++;
            $display("FAIL %s dut%0d: got state=%0d out=%b cnt=%0d, expected state=%0d out=%b cnt=%0d",
                     nm, id, ast, ao, ac, est, eo, ec);
        end
    endtask

    function automatic void push(input int id, input int st, input bit o,
                                 input int c, input string nm);
        exp_t e;
        e.id  = id;
        e.st  = st[4:0];
        e.o   = o;
        e.cnt = ecnt(c);
        e.nm  = nm;
        q.push_back(e);
    endfunction

    // Inputs change 2 time units after a rising edge; the expectations
    // pushed alongside describe the state after the following edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one time unit after each rising edge, everything queued in
    // the previous cycle is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                compare(e.nm, e.id, e.st, e.o, e.cnt);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        en_v   = 4'b0000;
        data_v = 4'b0000;
        repeat (2) @(posedge clk);
        #3;
        for (int id = 0; id < 4; id++) begin
            compare("reset_state", id, 5'd0, 1'b0, 8'd0);
        end
        reset = 1'b0;

        // 1011 stream on overlapping (A) and non-overlapping (B) detectors
        for (int i = 0; i < 7; i++) begin
            cyc();
            en_v      = 4'b0011;
            data_v[0] = t1_bits[i][0];
            data_v[1] = t1_bits[i][0];
            push(0, t1_sa[i], (t1_sa[i] == 4), t1_ca[i], "overlap_stream");
            push(1, t1_sb[i], (t1_sb[i] == 4), t1_cb[i], "nonoverlap_stream");
        end

        // Enable gating on A (starts in match state); B stays disabled
        for (int i = 0; i < 9; i++) begin
            cyc();
            en_v      = {3'b000, t3_en[i]};
            data_v[0] = t3_d[i];
            data_v[1] = t3_d[i];
            push(0, t3_sa[i], (t3_sa[i] == 4), t3_ca[i], "en_gating");
            push(1, 1, 1'b0, 1, "disabled_hold");
        end

        // Bring A to state 3, then pulse reset between edges
        for (int i = 0; i < 3; i++) begin
            cyc();
            en_v      = 4'b0001;
            data_v[0] = t4_bits[i][0];
            push(0, t4_sa[i], 1'b0, 3, "pre_reset");
        end
        cyc();
        en_v = 4'b0000;
        #1;
        reset = 1'b1;
        #1;
        compare("async_reset_a", 0, 5'd0, 1'b0, 8'd0);
        compare("async_reset_b", 1, 5'd0, 1'b0, 8'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            en_v      = 4'b0001;
            data_v[0] = t4_bits[i][0];
            push(0, t4_sa[i], (t4_sa[i] == 4), t4_ca[i], "post_reset_match");
        end
        cyc();
        en_v = 4'b0000;
        push(0, 4, 1'b1, 1, "post_reset_hold");

        // PAT_LEN=1, CNT_W=2: continuous match and counter saturation
        for (int i = 0; i < 6; i++) begin
            cyc();
            en_v      = 4'b0100;
            data_v[2] = 1'b1;
            push(2, 1, 1'b1, (i + 1 > 3) ? 3 : i + 1, "len1_saturate");
        end
        cyc();
        en_v      = 4'b0100;
        data_v[2] = 1'b0;
        push(2, 0, 1'b0, 3, "len1_drop");

        // 110 pattern: fallback from a partial match
        for (int i = 0; i < 4; i++) begin
            cyc();
            en_v      = 4'b1000;
            data_v[3] = t6_bits[i][0];
            push(3, t6_sd[i], (t6_sd[i] == 3), t6_cd[i], "fallback_110");
        end

        cyc();
        en_v = 4'b0000;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
